beam_input_pio: RTL and testbench

BEAM_INPUT_PIO -- requirements
Module: beam_input_pio

---
 rtl/beam_input_pio.sv | 137 +++++++++++++
 tb/tb_beam_input_pio.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/beam_input_pio.sv
// Debounced beam/button input PIO with Avalon-MM registers (DATA, IRQ_MASK, EDGE_CAPTURE, EDGE_MODE) and level irq.
// Read latency 1 cycle, no backpressure; debounce counters present only with BEAM_INPUT_PIO_DEBOUNCE_EN defined.
module beam_input_pio #(
  parameter int CHANNELS        = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [CHANNELS-1:0] beam_in,
  input  logic [1:0]          address,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic                irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_MODE = 2'd3;

  if (CHANNELS < 1 || CHANNELS > 32 || DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_param_check
    $error("beam_input_pio: CHANNELS or DEBOUNCE_CYCLES out of legal range");
  end

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [CHANNELS-1:0] stable;
  logic [CHANNELS-1:0] stable_nxt;
  logic [CHANNELS-1:0] irq_mask;
  logic [CHANNELS-1:0] edge_cap;
  logic [CHANNELS-1:0] edge_mode;
  logic [CHANNELS-1:0] cap_set;
  logic [CHANNELS-1:0] cap_clr;
  logic [CHANNELS-1:0] wr_val;
  logic [CHANNELS-1:0] rd_val;
  logic                unused_wdata;

  assign wr_val       = writedata[CHANNELS-1:0];
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= beam_in;
      sync2 <= sync1;
    end
  end

`ifdef BEAM_INPUT_PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt     [CHANNELS];
  logic [CW-1:0] cnt_nxt [CHANNELS];

  // Counter only runs while the synchronized level disagrees with the accepted one.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (sync2[i] == stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        stable_nxt[i] = sync2[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end
`else
  always_comb begin
    stable_nxt = sync2;
  end
`endif

  // Capture is taken from the accepted-level change itself, in the same cycle it lands.
  always_comb begin
    cap_set = (~edge_mode & ~stable & stable_nxt) | (edge_mode & stable & ~stable_nxt);
    cap_clr = '0;
    if (write && address == ADDR_EDGE) begin
      cap_clr = wr_val;
    end
  end

  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_DATA: rd_val = stable;
      ADDR_MASK: rd_val = irq_mask;
      ADDR_EDGE: rd_val = edge_cap;
      ADDR_MODE: rd_val = edge_mode;
      default:   rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      stable    <= '0;
      irq_mask  <= '0;
      edge_cap  <= '0;
      edge_mode <= '0;
      readdata  <= '0;
      irq       <= 1'b0;
    end else begin
      stable   <= stable_nxt;
      edge_cap <= (edge_cap & ~cap_clr) | cap_set;
      irq      <= |(edge_cap & irq_mask);
      if (read) begin
        readdata <= 32'(rd_val);
      end
      if (write && address == ADDR_MASK) begin
        irq_mask <= wr_val;
      end
      if (write && address == ADDR_MODE) begin
        edge_mode <= wr_val;
      end
    end
  end

endmodule

// File: tb/tb_beam_input_pio.sv
// Directed bench for beam_input_pio (CHANNELS=4, DEBOUNCE_CYCLES=4); adapts acceptance latency to BEAM_INPUT_PIO_DEBOUNCE_EN.
module tb_beam_input_pio;
  localparam int CH = 4;
  localparam int DC = 4;
`ifdef BEAM_INPUT_PIO_DEBOUNCE_EN
  localparam int LAT = 2 + DC;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] beam;
  logic [1:0]    address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          irq;
  logic [31:0]   rv;
  int            n_tests = 0;
  int            n_fail  = 0;

  beam_input_pio #(.CHANNELS(CH), .DEBOUNCE_CYCLES(DC)) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .beam_in    (beam),
    .address    (address),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick();
    write     = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    tick();
    read    = 1'b0;
    d       = readdata;
  endtask

  initial begin
    rst = 1'b1; beam = '0; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    #2;
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    tick(2);
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), rv);
      check($sformatf("rst_reg%0d", a), rv, 32'h0);
    end

    // Channel 0 rising: exact acceptance point through the held read.
    beam = 4'h1; address = 2'd0; read = 1'b1;
    tick(LAT);
    check("data_before_accept", readdata, 32'h0);
    tick();
    check("data_accept", readdata, 32'h1);
    read = 1'b0;
    rd(2'd2, rv); check("cap_rise_ch0", rv, 32'h1);
    check("irq_masked_off", 32'(irq), 32'h0);
    wr(2'd2, 32'h1);
    rd(2'd2, rv); check("cap_w1c", rv, 32'h0);

`ifdef BEAM_INPUT_PIO_DEBOUNCE_EN
    // Three-cycle glitch on channel 1 must not be accepted.
    beam = 4'h3;
    tick(3);
    beam = 4'h1;
    tick(10);
    rd(2'd0, rv); check("glitch_data", rv, 32'h1);
    rd(2'd2, rv); check("glitch_cap", rv, 32'h0);
`else
    // One-cycle pulse on channel 3 passes straight through the 1-cycle filter.
    beam = 4'h9; address = 2'd0; read = 1'b1;
    tick();
    beam = 4'h1;
    tick(2);
    check("pulse_before", readdata, 32'h1);
    tick();
    check("pulse_high", readdata, 32'h9);
    tick();
    check("pulse_after", readdata, 32'h1);
    read = 1'b0;
    rd(2'd2, rv); check("pulse_cap", rv, 32'h8);
    wr(2'd2, 32'h8);
`endif

    // Falling-edge capture on channel 2 drives irq; W1C drops it one cycle later.
    wr(2'd1, 32'h4);
    wr(2'd3, 32'h4);
    beam = 4'h5;
    tick(LAT + 2);
    rd(2'd2, rv); check("mode_fall_ignores_rise", rv, 32'h0);
    check("irq_idle", 32'(irq), 32'h0);
    beam = 4'h1;
    tick(LAT + 1);
    check("irq_fall", 32'(irq), 32'h1);
    rd(2'd2, rv); check("cap_fall_ch2", rv, 32'h4);
    address = 2'd2; writedata = 32'h4; write = 1'b1;
    tick();
    write = 1'b0;
    check("irq_w1c_edge", 32'(irq), 32'h1);
    tick();
    check("irq_w1c_next", 32'(irq), 32'h0);

    // W1C colliding with a fresh channel-0 capture: the set wins.
    beam = 4'h0;
    tick(LAT + 2);
    rd(2'd2, rv); check("mode_rise_ignores_fall", rv, 32'h0);
    beam = 4'h1;
    tick(LAT - 1);
    address = 2'd2; writedata = 32'h1; write = 1'b1;
    tick();
    write = 1'b0;
    rd(2'd2, rv); check("set_beats_w1c", rv, 32'h1);
    check("irq_mask_blocks", 32'(irq), 32'h0);
    wr(2'd2, 32'h1);

    // Simultaneous read/write returns the old value; upper writedata bits dropped.
    address = 2'd1; writedata = 32'hFFFF_FFF3; read = 1'b1; write = 1'b1;
    tick();
    read = 1'b0; write = 1'b0;
    check("rw_old_value", readdata, 32'h4);
    rd(2'd1, rv); check("mask_upper_ignored", rv, 32'h3);
    wr(2'd1, 32'h0);
    check("readdata_held", readdata, 32'h3);
    wr(2'd0, 32'hF);
    rd(2'd0, rv); check("data_write_ignored", rv, 32'h1);
    rd(2'd3, rv); check("mode_readback", rv, 32'h4);

    // Reset in the middle of a channel-1 transition.
    wr(2'd1, 32'hF);
    wr(2'd3, 32'h8);
    beam = 4'h3;
`ifdef BEAM_INPUT_PIO_DEBOUNCE_EN
    tick(4);
`else
    tick(1);
`endif
    rst = 1'b1;
    #1;
    check("midrst_readdata", readdata, 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    beam = 4'h0;
    tick(2);
    rst = 1'b0;
    tick(LAT + 3);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), rv);
      check($sformatf("midrst_reg%0d", a), rv, 32'h0);
    end
    check("midrst_irq_after", 32'(irq), 32'h0);

    // Input held high across reset release is accepted after the full latency.
    beam = 4'h1;
    rst  = 1'b1;
    address = 2'd0; read = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(LAT);
    check("held_before_accept", readdata, 32'h0);
    tick();
    check("held_accept", readdata, 32'h1);
    read = 1'b0;
    rd(2'd2, rv); check("held_cap", rv, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
